// File: rtl/ascii_seq_tx.sv
// ASCII command-frame transmitter: NUL, decimal digits, operator, letters, NUL, then one idle gap.
// Optional build macro ASCII_SEQ_TX_ERR_INJECT_EN adds inject_err, which replaces the operator with '?'.
module ascii_seq_tx #(
  parameter int CLKS_PER_CHAR = 2604,
  parameter int NUM_W         = 10,
  parameter int DIG_MAX       = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ASCII_SEQ_TX_ERR_INJECT_EN
  input  logic             inject_err,
`endif
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic             op_mul,
  input  logic [4:0]       letter_base,
  input  logic [3:0]       letter_cnt,
  output logic             busy,
  output logic [7:0]       ascii_char,
  output logic             char_valid,
  output logic             char_strobe,
  output logic             done
);

  localparam int BAUD_W = (CLKS_PER_CHAR > 2) ? $clog2(CLKS_PER_CHAR) : 1;
  localparam int DIG_W  = $clog2(DIG_MAX + 1);
  localparam int DIG_N  = 1 << DIG_W;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_CHAR - 1);
  localparam logic [DIG_W-1:0]  CONV_LAST = DIG_W'(DIG_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_NUL0, S_DIG, S_OP, S_LET, S_NUL1, S_GAP
  } state_t;

  state_t            state_q;
  logic [NUM_W-1:0]  val_q;
  logic [3:0]        dig_q [DIG_N];
  logic [DIG_W-1:0]  ndig_q;
  logic [DIG_W-1:0]  step_q;
  logic              op_mul_q;
  logic              inj_q;
  logic [4:0]        base_q;
  logic [3:0]        cnt_q;
  logic [3:0]        let_i_q;
  logic [BAUD_W-1:0] baud_q;
  logic              busy_q;
  logic [7:0]        char_q;
  logic              valid_q;
  logic              strobe_q;
  logic              done_q;

  logic [NUM_W-1:0]  quot_d;
  logic [3:0]        rem_d;
  logic [3:0]        let_last_d;
  logic [7:0]        op_char_d;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // 6-bit sum keeps letter_base + index free of overflow before the mod-26 wrap.
  function automatic logic [7:0] letter_char(input logic [4:0] base, input logic [3:0] idx);
    logic [5:0] s;
    s = {1'b0, base} + {2'b00, idx};
    s = s % 6'd26;
    return 8'h41 + {2'b00, s};
  endfunction

  assign quot_d     = val_q / NUM_W'(10);
  assign rem_d      = 4'(val_q % NUM_W'(10));
  assign let_last_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

`ifdef ASCII_SEQ_TX_ERR_INJECT_EN
  assign op_char_d = inj_q ? 8'h3F : (op_mul_q ? 8'h2A : 8'h2B);
`else
  assign op_char_d = op_mul_q ? 8'h2A : 8'h2B;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      val_q    <= '0;
      ndig_q   <= '0;
      step_q   <= '0;
      op_mul_q <= 1'b0;
      inj_q    <= 1'b0;
      base_q   <= '0;
      cnt_q    <= '0;
      let_i_q  <= '0;
      baud_q   <= '0;
      busy_q   <= 1'b0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DIG_N; i++) dig_q[i] <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            val_q    <= num;
            op_mul_q <= op_mul;
`ifdef ASCII_SEQ_TX_ERR_INJECT_EN
            inj_q    <= inject_err;
`else
            inj_q    <= 1'b0;
`endif
            base_q   <= letter_base;
            cnt_q    <= letter_cnt;
            step_q   <= '0;
            ndig_q   <= DIG_W'(1);
            busy_q   <= 1'b1;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          dig_q[step_q] <= rem_d;
          if (val_q != '0) ndig_q <= step_q + 1'b1;
          val_q <= quot_d;
          if (step_q == CONV_LAST) begin
            state_q  <= S_NUL0;
            char_q   <= 8'h00;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
            baud_q   <= BAUD_MAX;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_GAP: begin
          if (baud_q == BAUD_W'(1)) done_q <= 1'b1;
          if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          // Character states: hold for the baud period, then load the next character.
          if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
          end else begin
            baud_q   <= BAUD_MAX;
            strobe_q <= 1'b1;
            case (state_q)
              S_NUL0: begin
                step_q  <= ndig_q - 1'b1;
                char_q  <= digit_char(dig_q[ndig_q - 1'b1]);
                state_q <= S_DIG;
              end
              S_DIG: begin
                if (step_q == '0) begin
                  char_q  <= op_char_d;
                  state_q <= S_OP;
                end else begin
                  step_q <= step_q - 1'b1;
                  char_q <= digit_char(dig_q[step_q - 1'b1]);
                end
              end
              S_OP: begin
                let_i_q <= '0;
                char_q  <= letter_char(base_q, 4'd0);
                state_q <= S_LET;
              end
              S_LET: begin
                if (let_i_q == let_last_d) begin
                  char_q  <= 8'h00;
                  state_q <= S_NUL1;
                end else begin
                  let_i_q <= let_i_q + 4'd1;
                  char_q  <= letter_char(base_q, let_i_q + 4'd1);
                end
              end
              S_NUL1: begin
                char_q   <= 8'h00;
                valid_q  <= 1'b0;
                strobe_q <= 1'b0;
                state_q  <= S_GAP;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign ascii_char  = char_q;
  assign char_valid  = valid_q;
  assign char_strobe = strobe_q;
  assign done        = done_q;

endmodule
